// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage
//  Purpose  : Registered RV32I decode stage (optional M and Zicsr) between
//             fetch and execute. Valid/ready handshake, one-entry skid
//             buffer, flush, and a registered o_ready.
//  Revision : 1.0  initial release
// ============================================================================
module decode_stage #(
  parameter bit          ENABLE_M   = 1'b1,
  parameter bit          ENABLE_CSR = 1'b1,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [4:0]  o_rd_addr,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  output logic [31:0] o_imm,
  output logic [4:0]  o_alu_op,
  output logic        o_rs1_pc,
  output logic        o_rs2_imm,
  output logic        o_branch,
  output logic [2:0]  o_branch_type,
  output logic        o_jump,
  output logic [2:0]  o_loadstore,
  output logic        o_load_zeroextend,
  output logic        o_csr,
  output logic [1:0]  o_csr_op,
  output logic        o_csr_imm,
  output logic        o_system,
  output logic        o_illegal
);

  localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] C_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] C_OPC_OP     = 7'b0110011;
  localparam logic [6:0] C_OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] C_OPC_SYSTEM = 7'b1110011;

  // Decoded payload held in the main and skid registers.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rd_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] imm;
    logic [4:0]  alu_op;
    logic        rs1_pc;
    logic        rs2_imm;
    logic        branch;
    logic [2:0]  branch_type;
    logic        jump;
    logic [2:0]  loadstore;
    logic        load_zeroextend;
    logic        csr;
    logic [1:0]  csr_op;
    logic        csr_imm;
    logic        system;
    logic        illegal;
  } dec_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        is_muldiv;
  dec_t        dec_in;

  dec_t        main_q, main_d;
  dec_t        skid_q, skid_d;
  logic        valid_q, valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic        accept;
  logic        load_main;

  assign opcode    = i_instr[6:0];
  assign funct3    = i_instr[14:12];
  assign funct7    = i_instr[31:25];
  assign is_muldiv = ENABLE_M && (funct7 == 7'b0000001);

  assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign imm_u = {i_instr[31:12], 12'h000};
  assign imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

  // Combinational decode of the incoming instruction, with illegal masking.
  always_comb begin : p_decode
    logic ill;
    ill                    = 1'b0;
    dec_in                 = '0;
    dec_in.instr           = i_instr;
    dec_in.pc              = i_pc;
    dec_in.rd_addr         = i_instr[11:7];
    dec_in.rs1_addr        = i_instr[19:15];
    dec_in.rs2_addr        = i_instr[24:20];
    dec_in.rs2_imm         = (opcode != C_OPC_OP);
    dec_in.branch_type     = funct3;
    dec_in.load_zeroextend = funct3[2];
    dec_in.csr_op          = funct3[1:0];
    dec_in.csr_imm         = funct3[2];
    case (opcode)
      C_OPC_LUI: begin
        dec_in.imm      = imm_u;
        dec_in.rs1_addr = 5'd0;
      end
      C_OPC_AUIPC: begin
        dec_in.imm    = imm_u;
        dec_in.rs1_pc = 1'b1;
      end
      C_OPC_JAL: begin
        dec_in.imm    = imm_j;
        dec_in.rs1_pc = 1'b1;
        dec_in.jump   = 1'b1;
      end
      C_OPC_JALR: begin
        dec_in.imm  = imm_i;
        dec_in.jump = 1'b1;
        ill         = (funct3 != 3'b000);
      end
      C_OPC_BRANCH: begin
        dec_in.imm     = imm_b;
        dec_in.rs1_pc  = 1'b1;
        dec_in.branch  = 1'b1;
        dec_in.rd_addr = 5'd0;
        ill            = (funct3[2:1] == 2'b01);
      end
      C_OPC_LOAD: begin
        dec_in.imm       = imm_i;
        dec_in.loadstore = {1'b0, funct3[1:0] + 2'd1};
        ill              = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      C_OPC_STORE: begin
        dec_in.imm       = imm_s;
        dec_in.loadstore = {1'b1, funct3[1:0] + 2'd1};
        dec_in.rd_addr   = 5'd0;
        ill              = (funct3 > 3'b010);
      end
      C_OPC_OPIMM: begin
        dec_in.imm = imm_i;
        // Bit 30 only selects SRA for right shifts; elsewhere it is immediate data.
        dec_in.alu_op = {1'b0, (funct3 == 3'b101) && i_instr[30], funct3};
        if (funct3 == 3'b001) begin
          ill = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          ill = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
        end
      end
      C_OPC_OP: begin
        dec_in.alu_op = {is_muldiv, funct7[5], funct3};
        case (funct7)
          7'b0000000: ill = 1'b0;
          7'b0100000: ill = (funct3 != 3'b000) && (funct3 != 3'b101);
          7'b0000001: ill = !ENABLE_M;
          default:    ill = 1'b1;
        endcase
      end
      C_OPC_FENCE: begin
        dec_in.imm     = imm_i;
        dec_in.rd_addr = 5'd0;
      end
      C_OPC_SYSTEM: begin
        dec_in.imm = {20'd0, i_instr[31:20]};
        if (!ENABLE_CSR) begin
          ill = 1'b1;
        end else if (funct3 == 3'b000) begin
          dec_in.system  = 1'b1;
          dec_in.rd_addr = 5'd0;
        end else if (funct3 == 3'b100) begin
          ill = 1'b1;
        end else begin
          dec_in.csr = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    // An illegal instruction must not cause any architectural side effect.
    if (ill) begin
      dec_in.rd_addr   = 5'd0;
      dec_in.branch    = 1'b0;
      dec_in.jump      = 1'b0;
      dec_in.loadstore = 3'd0;
      dec_in.csr       = 1'b0;
      dec_in.system    = 1'b0;
    end
    dec_in.illegal = ill;
  end

  // o_ready is the registered skid state, so i_ready never reaches it combinationally.
  assign o_ready   = !skid_valid_q;
  assign accept    = i_valid && !skid_valid_q;
  assign load_main = !valid_q || i_ready;

  // Next-state for main/skid: flush first, then drain skid, then accept.
  always_comb begin : p_next
    main_d       = main_q;
    skid_d       = skid_q;
    valid_d      = valid_q;
    skid_valid_d = skid_valid_q;
    if (i_flush) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end else if (load_main) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        valid_d      = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d  = dec_in;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec_in;
      skid_valid_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin : p_regs
    if (i_rst) begin
      main_q       <= '0;
      main_q.pc    <= RESET_PC;
      skid_q       <= '0;
      valid_q      <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      valid_q      <= valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign o_valid           = valid_q;
  assign o_instr           = main_q.instr;
  assign o_pc              = main_q.pc;
  assign o_rd_addr         = main_q.rd_addr;
  assign o_rs1_addr        = main_q.rs1_addr;
  assign o_rs2_addr        = main_q.rs2_addr;
  assign o_imm             = main_q.imm;
  assign o_alu_op          = main_q.alu_op;
  assign o_rs1_pc          = main_q.rs1_pc;
  assign o_rs2_imm         = main_q.rs2_imm;
  assign o_branch          = main_q.branch;
  assign o_branch_type     = main_q.branch_type;
  assign o_jump            = main_q.jump;
  assign o_loadstore       = main_q.loadstore;
  assign o_load_zeroextend = main_q.load_zeroextend;
  assign o_csr             = main_q.csr;
  assign o_csr_op          = main_q.csr_op;
  assign o_csr_imm         = main_q.csr_imm;
  assign o_system          = main_q.system;
  assign o_illegal         = main_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_stage
//  Purpose  : Self-checking bench for decode_stage. Two instances (full
//             feature set, and M/CSR disabled) share one stimulus stream and
//             are compared against a 2-deep FIFO model plus a field decoder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decode_stage;

  localparam logic [31:0] RESET_PC_A = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_B = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic        rs1_pc, rs2_imm, branch;
    logic [2:0]  btype;
    logic        jump;
    logic [2:0]  ls;
    logic        lzx, csr;
    logic [1:0]  csr_op;
    logic        csr_imm, sys, ill;
  } out_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } txn_t;

  logic        clk;
  logic        i_rst, i_flush, i_valid, i_ready;
  logic [31:0] i_instr, i_pc;

  logic        a_valid, a_ready, a_rs1_pc, a_rs2_imm, a_branch, a_jump, a_lzx, a_csr, a_csr_imm, a_sys, a_ill;
  logic        b_valid, b_ready, b_rs1_pc, b_rs2_imm, b_branch, b_jump, b_lzx, b_csr, b_csr_imm, b_sys, b_ill;
  logic [31:0] a_instr, a_pc, a_imm, b_instr, b_pc, b_imm;
  logic [4:0]  a_rd, a_rs1, a_rs2, a_alu, b_rd, b_rs1, b_rs2, b_alu;
  logic [2:0]  a_btype, a_ls, b_btype, b_ls;
  logic [1:0]  a_csr_op, b_csr_op;
  out_t        obs_a, obs_b;

  int   errors = 0;
  int   checks = 0;
  txn_t q[$];

  decode_stage #(.ENABLE_M(1'b1), .ENABLE_CSR(1'b1), .RESET_PC(RESET_PC_A)) u_dut_a (
    .i_clk(clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(a_ready),
    .i_instr(i_instr), .i_pc(i_pc), .o_valid(a_valid), .i_ready(i_ready),
    .o_instr(a_instr), .o_pc(a_pc), .o_rd_addr(a_rd), .o_rs1_addr(a_rs1), .o_rs2_addr(a_rs2),
    .o_imm(a_imm), .o_alu_op(a_alu), .o_rs1_pc(a_rs1_pc), .o_rs2_imm(a_rs2_imm),
    .o_branch(a_branch), .o_branch_type(a_btype), .o_jump(a_jump), .o_loadstore(a_ls),
    .o_load_zeroextend(a_lzx), .o_csr(a_csr), .o_csr_op(a_csr_op), .o_csr_imm(a_csr_imm),
    .o_system(a_sys), .o_illegal(a_ill)
  );

  decode_stage #(.ENABLE_M(1'b0), .ENABLE_CSR(1'b0), .RESET_PC(RESET_PC_B)) u_dut_b (
    .i_clk(clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(b_ready),
    .i_instr(i_instr), .i_pc(i_pc), .o_valid(b_valid), .i_ready(i_ready),
    .o_instr(b_instr), .o_pc(b_pc), .o_rd_addr(b_rd), .o_rs1_addr(b_rs1), .o_rs2_addr(b_rs2),
    .o_imm(b_imm), .o_alu_op(b_alu), .o_rs1_pc(b_rs1_pc), .o_rs2_imm(b_rs2_imm),
    .o_branch(b_branch), .o_branch_type(b_btype), .o_jump(b_jump), .o_loadstore(b_ls),
    .o_load_zeroextend(b_lzx), .o_csr(b_csr), .o_csr_op(b_csr_op), .o_csr_imm(b_csr_imm),
    .o_system(b_sys), .o_illegal(b_ill)
  );

  assign obs_a = {a_instr, a_pc, a_rd, a_rs1, a_rs2, a_imm, a_alu, a_rs1_pc, a_rs2_imm, a_branch,
                  a_btype, a_jump, a_ls, a_lzx, a_csr, a_csr_op, a_csr_imm, a_sys, a_ill};
  assign obs_b = {b_instr, b_pc, b_rd, b_rs1, b_rs2, b_imm, b_alu, b_rs1_pc, b_rs2_imm, b_branch,
                  b_btype, b_jump, b_ls, b_lzx, b_csr, b_csr_op, b_csr_imm, b_sys, b_ill};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two's-complement sign extension of a width-bit field by plain arithmetic.
  function automatic logic [31:0] sext(input logic [31:0] val, input int width);
    if (val[width-1]) return val - (32'd1 << width);
    return val;
  endfunction

  // Reference decoder: instruction semantics from the RV32I/M/Zicsr rules.
  function automatic out_t model(input logic [31:0] ins, input logic [31:0] pc, input bit en_m, input bit en_csr);
    out_t       e;
    bit         ill;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ins[14:12];
    f7 = ins[31:25];
    ill = 1'b0;
    e = '0;
    e.instr = ins;  e.pc = pc;
    e.rd = ins[11:7];  e.rs1 = ins[19:15];  e.rs2 = ins[24:20];
    e.btype = f3;  e.lzx = f3[2];  e.csr_op = f3[1:0];  e.csr_imm = f3[2];
    e.rs2_imm = (ins[6:0] != 7'h33);
    case (ins[6:0])
      7'h37: begin e.imm = ins & 32'hFFFF_F000; e.rs1 = 5'd0; end
      7'h17: begin e.imm = ins & 32'hFFFF_F000; e.rs1_pc = 1'b1; end
      7'h6F: begin
        e.imm = sext({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
        e.rs1_pc = 1'b1; e.jump = 1'b1;
      end
      7'h67: begin e.imm = sext(ins[31:20], 12); e.jump = 1'b1; ill = (f3 != 0); end
      7'h63: begin
        e.imm = sext({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
        e.rs1_pc = 1'b1; e.branch = 1'b1; e.rd = 5'd0;
        ill = (f3 == 2) || (f3 == 3);
      end
      7'h03: begin
        e.imm = sext(ins[31:20], 12);
        e.ls = 3'(f3[1:0]) + 3'd1;
        ill = (f3 == 3) || (f3 == 6) || (f3 == 7);
      end
      7'h23: begin
        e.imm = sext({ins[31:25], ins[11:7]}, 12);
        e.ls = 3'd4 + 3'(f3[1:0]) + 3'd1;
        e.rd = 5'd0;
        ill = (f3 > 2);
      end
      7'h13: begin
        e.imm = sext(ins[31:20], 12);
        e.alu = {1'b0, (f3 == 5) && (f7 == 7'h20), f3};
        if (f3 == 1) ill = (f7 != 0);
        if (f3 == 5) ill = !((f7 == 0) || (f7 == 7'h20));
        if (f3 == 5 && ill) e.alu = {1'b0, f7[5], f3};
      end
      7'h33: begin
        if (f7 == 0) e.alu = {2'b00, f3};
        else if (f7 == 7'h20) begin e.alu = {2'b01, f3}; ill = !((f3 == 0) || (f3 == 5)); end
        else if (f7 == 7'h01 && en_m) e.alu = {2'b10, f3};
        else begin e.alu = {1'b0, f7[5], f3}; ill = 1'b1; end
      end
      7'h0F: begin e.imm = sext(ins[31:20], 12); e.rd = 5'd0; end
      7'h73: begin
        e.imm = {20'd0, ins[31:20]};
        if (!en_csr) ill = 1'b1;
        else if (f3 == 0) begin e.sys = 1'b1; e.rd = 5'd0; end
        else if (f3 == 4) ill = 1'b1;
        else e.csr = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      e.ill = 1'b1; e.rd = 5'd0; e.branch = 1'b0; e.jump = 1'b0;
      e.ls = 3'd0; e.csr = 1'b0; e.sys = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input out_t obs, input out_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s instr=%h observed=%h expected=%h", tag, exp.instr, obs, exp);
    end
  endtask

  // Compare both instances against the FIFO model and the reference decoder.
  task automatic check_outputs();
    out_t ea, eb, oa, ob;
    chk("a_valid", 32'(a_valid), 32'(q.size() > 0));
    chk("a_ready", 32'(a_ready), 32'(q.size() < 2));
    chk("b_valid", 32'(b_valid), 32'(q.size() > 0));
    chk("b_ready", 32'(b_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      ea = model(q[0].instr, q[0].pc, 1'b1, 1'b1);
      eb = model(q[0].instr, q[0].pc, 1'b0, 1'b0);
      oa = obs_a;
      ob = obs_b;
      // Only the CSR address bits of a SYSTEM immediate are defined.
      if (q[0].instr[6:0] == 7'h73) begin
        ea.imm[31:12] = '0; oa.imm[31:12] = '0;
        eb.imm[31:12] = '0; ob.imm[31:12] = '0;
      end
      chk_out("dec_a", oa, ea);
      chk_out("dec_b", ob, eb);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check at negedge.
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input bit rdy, input bit fl, input bit rs);
    bit can_accept;
    i_valid = v; i_instr = ins; i_pc = pc; i_ready = rdy; i_flush = fl; i_rst = rs;
    @(posedge clk);
    if (rs || fl) begin
      q.delete();
    end else begin
      can_accept = (q.size() < 2);
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (v && can_accept) q.push_back('{ins, pc});
    end
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] x;
    x = $urandom;
    if ($urandom_range(0, 7) != 0) begin
      case ($urandom_range(0, 10))
        0: x[6:0] = 7'h37;  1: x[6:0] = 7'h17;  2: x[6:0] = 7'h6F;  3: x[6:0] = 7'h67;
        4: x[6:0] = 7'h63;  5: x[6:0] = 7'h03;  6: x[6:0] = 7'h23;  7: x[6:0] = 7'h13;
        8: x[6:0] = 7'h33;  9: x[6:0] = 7'h0F;  default: x[6:0] = 7'h73;
      endcase
    end
    case ($urandom_range(0, 3))
      0: x[31:25] = 7'h00;
      1: x[31:25] = 7'h20;
      2: x[31:25] = 7'h01;
      default: ;
    endcase
    return x;
  endfunction

  initial begin
    i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_instr = '0; i_pc = '0;

    // Reset state
    step(0, 32'h0, 32'h0, 0, 0, 1);
    step(0, 32'h0, 32'h0, 0, 0, 1);
    chk("rst_a_pc", a_pc, RESET_PC_A);
    chk("rst_b_pc", b_pc, RESET_PC_B);
    chk("rst_a_instr", a_instr, 32'h0);
    chk("rst_a_imm", a_imm, 32'h0);

    // ADD x3,x1,x2
    step(1, 32'h002081B3, 32'h100, 1, 0, 0);
    chk("add_rd", 32'(a_rd), 32'd3);
    chk("add_rs1", 32'(a_rs1), 32'd1);
    chk("add_rs2", 32'(a_rs2), 32'd2);
    chk("add_alu", 32'(a_alu), 32'd0);
    chk("add_rs2imm", 32'(a_rs2_imm), 32'd0);
    chk("add_pc", a_pc, 32'h100);

    // MUL x3,x1,x2 with and without M
    step(1, 32'h022081B3, 32'h104, 1, 0, 0);
    chk("mul_alu", 32'(a_alu), 32'b10000);
    chk("mul_ill_a", 32'(a_ill), 32'd0);
    chk("mul_ill_b", 32'(b_ill), 32'd1);
    chk("mul_rd_b", 32'(b_rd), 32'd0);

    // LW x5,-4(x2)
    step(1, 32'hFFC12283, 32'h108, 1, 0, 0);
    chk("lw_imm", a_imm, 32'hFFFF_FFFC);
    chk("lw_ls", 32'(a_ls), 32'b011);
    chk("lw_rd", 32'(a_rd), 32'd5);

    // BEQ x0,x0,-4
    step(1, 32'hFE000EE3, 32'h10C, 1, 0, 0);
    chk("beq_branch", 32'(a_branch), 32'd1);
    chk("beq_imm", a_imm, 32'hFFFF_FFFC);
    chk("beq_rs1pc", 32'(a_rs1_pc), 32'd1);
    chk("beq_rd", 32'(a_rd), 32'd0);

    // CSRRW x1,mstatus,x2
    step(1, 32'h300110F3, 32'h110, 1, 0, 0);
    chk("csr_csr", 32'(a_csr), 32'd1);
    chk("csr_op", 32'(a_csr_op), 32'b01);
    chk("csr_addr", {20'd0, a_imm[11:0]}, 32'h300);
    chk("csr_rd", 32'(a_rd), 32'd1);
    chk("csr_rs1", 32'(a_rs1), 32'd2);
    chk("csr_ill_b", 32'(b_ill), 32'd1);
    step(0, 32'h0, 32'h0, 1, 0, 0);

    // Back-pressure: A in main, B in skid, C refused, then drain in order.
    step(1, 32'h00100093, 32'h200, 0, 0, 0);
    step(1, 32'h00200113, 32'h204, 0, 0, 0);
    step(1, 32'h00300193, 32'h208, 0, 0, 0);
    chk("bp_main_A", a_instr, 32'h00100093);
    chk("bp_ready", 32'(a_ready), 32'd0);
    step(1, 32'h00300193, 32'h208, 1, 0, 0);
    chk("bp_main_B", a_instr, 32'h00200113);
    step(1, 32'h00300193, 32'h208, 1, 0, 0);
    chk("bp_main_C", a_instr, 32'h00300193);
    step(0, 32'h0, 32'h0, 1, 0, 0);

    // Flush with main+skid full and a same-cycle offer.
    step(1, 32'h00400213, 32'h300, 0, 0, 0);
    step(1, 32'h00500293, 32'h304, 0, 0, 0);
    step(1, 32'h00600313, 32'h308, 0, 1, 0);
    chk("fl_valid", 32'(a_valid), 32'd0);
    chk("fl_ready", 32'(a_ready), 32'd1);
    step(0, 32'h0, 32'h0, 1, 0, 0);
    chk("fl_dropped", 32'(a_valid), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, 0);
    end

    // Reset mid-stream
    step(1, 32'h00700393, 32'h400, 0, 0, 0);
    step(1, 32'h00800413, 32'h404, 0, 0, 0);
    step(1, 32'h00900493, 32'h408, 1, 0, 1);
    chk("mrst_valid", 32'(a_valid), 32'd0);
    chk("mrst_pc_a", a_pc, RESET_PC_A);
    chk("mrst_pc_b", b_pc, RESET_PC_B);
    step(1, 32'h00A00513, 32'h40C, 1, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
